// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Memory stage of a small RV32 pipeline. Non-memory instructions pass their
// ALU result through to writeback with one cycle of latency. Loads and stores
// are checked for a legal funct3 and for natural alignment. A good access
// starts a handshake with data memory and holds the pipeline until DM_ack.
// A bad access raises a one-cycle fault pulse and never reaches memory.
//
// Optional feature (macro LSU_TIMEOUT_EN): an ACCESS-cycle counter aborts a
// request that has not been acknowledged within TIMEOUT_CYCLES cycles.
//
// Ports
//   clk, rst_n               clock; synchronous active-low reset
//   EX_valid/opcode/fn_3     instruction from execute
//   ALU_alu_val              byte address (load/store) or writeback value
//   EX_rs2_val, EX_rd        store data, destination register
//   MEM_stall                high while an access is outstanding
//   DM_req/we/addr/wdata/be  data-memory request (all registered)
//   DM_ack, DM_rdata         data-memory completion and read word
//   MEM_wb_val/rd/wb_en      registered writeback
//   MEM_fault                one-cycle fault pulse
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EX_valid,
    input  logic [6:0]  EX_opcode,
    input  logic [2:0]  EX_fn_3,
    input  logic [31:0] ALU_alu_val,
    input  logic [31:0] EX_rs2_val,
    input  logic [4:0]  EX_rd,
    output logic        MEM_stall,
    output logic        DM_req,
    output logic        DM_we,
    output logic [31:0] DM_addr,
    output logic [31:0] DM_wdata,
    output logic [3:0]  DM_be,
    input  logic        DM_ack,
    input  logic [31:0] DM_rdata,
    output logic [31:0] MEM_wb_val,
    output logic [4:0]  MEM_rd,
    output logic        MEM_wb_en,
    output logic        MEM_fault
);

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Details of the outstanding access, needed again when the ack arrives.
    logic        r_is_store;
    logic [2:0]  r_fn3;
    logic [1:0]  r_addr_lo;
    logic [4:0]  r_rd;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_legal;
    logic        w_aligned;
    logic        w_start;
    logic        w_bad;
    logic        w_alu;
    logic        w_done;
    logic        w_abort;
    logic        w_tmo;

    // Byte enables by access width; halfword lanes are already aligned here.
    function automatic logic [3:0] f_be(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = 4'b0011 << lo;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across every lane it could land in.
    function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] rs2);
        logic [31:0] wd;
        case (size)
            2'b00:   wd = {4{rs2[7:0]}};
            2'b01:   wd = {2{rs2[15:0]}};
            default: wd = rs2;
        endcase
        return wd;
    endfunction

    // Pick the addressed lane out of the read word and extend it.
    function automatic logic [31:0] f_load_ext(input logic [2:0] fn3, input logic [1:0] lo,
                                               input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = rdata[{lo, 3'b000} +: 8];
        h = lo[1] ? rdata[31:16] : rdata[15:0];
        case (fn3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b100:  res = {24'd0, b};
            3'b101:  res = {16'd0, h};
            default: res = rdata;
        endcase
        return res;
    endfunction

    assign w_is_load  = (EX_opcode == OPC_LOAD);
    assign w_is_store = (EX_opcode == OPC_STORE);
    assign MEM_stall  = (r_state == ST_ACCESS);

    // Decode funct3 legality and natural alignment of the incoming access.
    always_comb begin
        w_legal   = 1'b0;
        w_aligned = 1'b1;
        case (EX_fn_3)
            3'b000, 3'b001, 3'b010: w_legal = w_is_load | w_is_store;
            3'b100, 3'b101:         w_legal = w_is_load;
            default:                w_legal = 1'b0;
        endcase
        case (EX_fn_3[1:0])
            2'b01:   w_aligned = (ALU_alu_val[0] == 1'b0);
            2'b10:   w_aligned = (ALU_alu_val[1:0] == 2'b00);
            default: w_aligned = 1'b1;
        endcase
    end

    // Next-state and per-cycle action decode.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_bad       = 1'b0;
        w_alu       = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (EX_valid) begin
                    if (!(w_is_load || w_is_store)) begin
                        w_alu = 1'b1;
                    end else if (w_legal && w_aligned) begin
                        w_start     = 1'b1;
                        w_state_nxt = ST_ACCESS;
                    end else begin
                        w_bad = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // An ack on the final allowed cycle still completes normally.
                if (DM_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_tmo) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] r_tmo_cnt;

    assign w_tmo = (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count ACCESS cycles; cleared whenever a new access is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (w_start) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_ACCESS && !w_tmo) begin
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
        end
    end
`else
    logic [31:0] w_unused_tmo;
    assign w_unused_tmo = 32'(TIMEOUT_CYCLES);
    assign w_tmo        = 1'b0;
`endif

    // Memory request, latched access details and writeback registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            DM_req     <= 1'b0;
            DM_we      <= 1'b0;
            DM_addr    <= 32'd0;
            DM_wdata   <= 32'd0;
            DM_be      <= 4'd0;
            MEM_wb_val <= 32'd0;
            MEM_rd     <= 5'd0;
            MEM_wb_en  <= 1'b0;
            MEM_fault  <= 1'b0;
            r_is_store <= 1'b0;
            r_fn3      <= 3'd0;
            r_addr_lo  <= 2'd0;
            r_rd       <= 5'd0;
        end else begin
            MEM_wb_en <= 1'b0;
            MEM_fault <= 1'b0;
            if (w_start) begin
                DM_req     <= 1'b1;
                DM_we      <= w_is_store;
                DM_addr    <= {ALU_alu_val[31:2], 2'b00};
                DM_wdata   <= w_is_store ? f_wdata(EX_fn_3[1:0], EX_rs2_val) : 32'd0;
                DM_be      <= f_be(EX_fn_3[1:0], ALU_alu_val[1:0]);
                r_is_store <= w_is_store;
                r_fn3      <= EX_fn_3;
                r_addr_lo  <= ALU_alu_val[1:0];
                r_rd       <= EX_rd;
            end
            if (w_alu) begin
                MEM_wb_val <= ALU_alu_val;
                MEM_rd     <= EX_rd;
                MEM_wb_en  <= (EX_rd != 5'd0);
            end
            if (w_bad) begin
                MEM_fault <= 1'b1;
            end
            if (w_done) begin
                DM_req <= 1'b0;
                DM_we  <= 1'b0;
                if (!r_is_store) begin
                    MEM_wb_val <= f_load_ext(r_fn3, r_addr_lo, DM_rdata);
                    MEM_rd     <= r_rd;
                    MEM_wb_en  <= (r_rd != 5'd0);
                end
            end
            if (w_abort) begin
                DM_req    <= 1'b0;
                DM_we     <= 1'b0;
                MEM_fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        EX_valid = 1'b0;
    logic [6:0]  EX_opcode = 7'd0;
    logic [2:0]  EX_fn_3 = 3'd0;
    logic [31:0] ALU_alu_val = 32'd0;
    logic [31:0] EX_rs2_val = 32'd0;
    logic [4:0]  EX_rd = 5'd0;
    logic        MEM_stall;
    logic        DM_req;
    logic        DM_we;
    logic [31:0] DM_addr;
    logic [31:0] DM_wdata;
    logic [3:0]  DM_be;
    logic        DM_ack = 1'b0;
    logic [31:0] DM_rdata = 32'd0;
    logic [31:0] MEM_wb_val;
    logic [4:0]  MEM_rd;
    logic        MEM_wb_en;
    logic        MEM_fault;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .EX_valid(EX_valid), .EX_opcode(EX_opcode), .EX_fn_3(EX_fn_3),
        .ALU_alu_val(ALU_alu_val), .EX_rs2_val(EX_rs2_val), .EX_rd(EX_rd),
        .MEM_stall(MEM_stall), .DM_req(DM_req), .DM_we(DM_we),
        .DM_addr(DM_addr), .DM_wdata(DM_wdata), .DM_be(DM_be),
        .DM_ack(DM_ack), .DM_rdata(DM_rdata),
        .MEM_wb_val(MEM_wb_val), .MEM_rd(MEM_rd),
        .MEM_wb_en(MEM_wb_en), .MEM_fault(MEM_fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] opc, input logic [2:0] fn3, input logic [31:0] val,
                         input logic [31:0] rs2, input logic [4:0] rd);
        EX_valid = 1'b1; EX_opcode = opc; EX_fn_3 = fn3;
        ALU_alu_val = val; EX_rs2_val = rs2; EX_rd = rd;
    endtask

    // Runs the ACCESS phase: raises DM_ack in the ack_at-th stall cycle (0 = never).
    task automatic run_access(input int ack_at, input logic [31:0] rdata, output int stall_cnt,
                              output logic req_ok, output logic wb_seen);
        logic [31:0] addr0;
        stall_cnt = 0; req_ok = 1'b1; wb_seen = 1'b0; addr0 = DM_addr;
        for (int i = 0; i < 40; i++) begin
            if (MEM_stall !== 1'b1) break;
            stall_cnt++;
            if (DM_req !== 1'b1 || DM_addr !== addr0) req_ok = 1'b0;
            if (MEM_wb_en !== 1'b0) wb_seen = 1'b1;
            if (stall_cnt == ack_at) begin
                DM_ack = 1'b1; DM_rdata = rdata;
            end
            tick();
            DM_ack = 1'b0; DM_rdata = 32'd0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        chk_cnt++; if ({DM_req, DM_we, MEM_wb_en, MEM_fault, MEM_stall} !== 5'b0) $display("FAIL reset_ctrl got=%b want=00000", {DM_req, DM_we, MEM_wb_en, MEM_fault, MEM_stall}); else pass_cnt++;
        chk_cnt++; if ({DM_addr, DM_wdata, DM_be} !== 68'd0) $display("FAIL reset_dm got=%h want=0", {DM_addr, DM_wdata, DM_be}); else pass_cnt++;
        chk_cnt++; if ({MEM_wb_val, MEM_rd} !== 37'd0) $display("FAIL reset_wb got=%h want=0", {MEM_wb_val, MEM_rd}); else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        issue(OP_ADDI, 3'b000, 32'h0000002A, 32'd0, 5'd5);
        tick();
        EX_valid = 1'b0;
        chk_cnt++; if (MEM_wb_val !== 32'h2A) $display("FAIL alu_val got=%h want=0000002a", MEM_wb_val); else pass_cnt++;
        chk_cnt++; if (MEM_rd !== 5'd5) $display("FAIL alu_rd got=%0d want=5", MEM_rd); else pass_cnt++;
        chk_cnt++; if ({MEM_wb_en, MEM_stall, DM_req} !== 3'b100) $display("FAIL alu_ctrl got=%b want=100", {MEM_wb_en, MEM_stall, DM_req}); else pass_cnt++;
        tick();
        chk_cnt++; if ({MEM_wb_en, MEM_wb_val} !== {1'b0, 32'h2A}) $display("FAIL alu_hold got=%h want=00000002a", {MEM_wb_en, MEM_wb_val}); else pass_cnt++;
        issue(OP_ADDI, 3'b000, 32'h00000077, 32'd0, 5'd0);
        tick();
        EX_valid = 1'b0;
        chk_cnt++; if ({MEM_wb_en, MEM_rd, MEM_wb_val} !== {1'b0, 5'd0, 32'h77}) $display("FAIL alu_rd0 got=%h want=000000077", {MEM_wb_en, MEM_rd, MEM_wb_val}); else pass_cnt++;
    endtask

    task automatic test_loads();
        logic [2:0]  fn_t  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ad_t  [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] rdt_t [4] = '{32'h80000000, 32'h80000000, 32'h80010000, 32'h80010000};
        logic [31:0] exp_t [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
        int          ack_t [4] = '{3, 3, 1, 2};
        logic [4:0]  rd_t  [4] = '{5'd5, 5'd6, 5'd3, 5'd2};
        int   sc;
        logic rok, wbs;
        for (int k = 0; k < 4; k++) begin
            issue(OP_LOAD, fn_t[k], ad_t[k], 32'hFFFFFFFF, rd_t[k]);
            tick();
            EX_valid = 1'b0;
            chk_cnt++; if ({DM_req, DM_we, DM_addr} !== {2'b10, 32'h100}) $display("FAIL load%0d_req got=%h want=200000100", k, {DM_req, DM_we, DM_addr}); else pass_cnt++;
            run_access(ack_t[k], rdt_t[k], sc, rok, wbs);
            chk_cnt++; if (sc !== ack_t[k] || rok !== 1'b1) $display("FAIL load%0d_stall got=%0d/%b want=%0d/1", k, sc, rok, ack_t[k]); else pass_cnt++;
            chk_cnt++; if (MEM_wb_val !== exp_t[k]) $display("FAIL load%0d_val got=%h want=%h", k, MEM_wb_val, exp_t[k]); else pass_cnt++;
            chk_cnt++; if ({MEM_wb_en, MEM_rd, DM_req} !== {1'b1, rd_t[k], 1'b0}) $display("FAIL load%0d_wb got=%b want=1%b0", k, {MEM_wb_en, MEM_rd, DM_req}, rd_t[k]); else pass_cnt++;
        end
        tick();
        chk_cnt++; if (MEM_wb_en !== 1'b0) $display("FAIL load_pulse got=%b want=0", MEM_wb_en); else pass_cnt++;
    endtask

    task automatic test_stores();
        logic [2:0]  fn_t [3] = '{3'b001, 3'b000, 3'b010};
        logic [31:0] ad_t [3] = '{32'h202, 32'h101, 32'h300};
        logic [31:0] rs_t [3] = '{32'h1234ABCD, 32'h000000EE, 32'hCAFEF00D};
        logic [31:0] wa_t [3] = '{32'h200, 32'h100, 32'h300};
        logic [31:0] wd_t [3] = '{32'hABCDABCD, 32'hEEEEEEEE, 32'hCAFEF00D};
        logic [3:0]  be_t [3] = '{4'b1100, 4'b0010, 4'b1111};
        int   sc;
        logic rok, wbs;
        for (int k = 0; k < 3; k++) begin
            issue(OP_STORE, fn_t[k], ad_t[k], rs_t[k], 5'd9);
            tick();
            EX_valid = 1'b0;
            chk_cnt++; if ({DM_req, DM_we, DM_be} !== {2'b11, be_t[k]}) $display("FAIL store%0d_be got=%b want=11%b", k, {DM_req, DM_we, DM_be}, be_t[k]); else pass_cnt++;
            chk_cnt++; if (DM_wdata !== wd_t[k] || DM_addr !== wa_t[k]) $display("FAIL store%0d_data got=%h/%h want=%h/%h", k, DM_wdata, DM_addr, wd_t[k], wa_t[k]); else pass_cnt++;
            run_access(1, 32'h5A5A5A5A, sc, rok, wbs);
            chk_cnt++; if (sc !== 1 || MEM_wb_en !== 1'b0 || MEM_wb_val !== 32'h00008001) $display("FAIL store%0d_wb got=%0d/%b/%h want=1/0/00008001", k, sc, MEM_wb_en, MEM_wb_val); else pass_cnt++;
        end
    endtask

    task automatic test_faults();
        logic [6:0]  op_t [4] = '{OP_LOAD, OP_STORE, OP_STORE, OP_LOAD};
        logic [2:0]  fn_t [4] = '{3'b010, 3'b001, 3'b100, 3'b011};
        logic [31:0] ad_t [4] = '{32'h101, 32'h203, 32'h000, 32'h008};
        for (int k = 0; k < 4; k++) begin
            issue(op_t[k], fn_t[k], ad_t[k], 32'h11111111, 5'd4);
            tick();
            EX_valid = 1'b0;
            chk_cnt++; if ({DM_req, MEM_stall, MEM_fault, MEM_wb_en} !== 4'b0010) $display("FAIL fault%0d got=%b want=0010", k, {DM_req, MEM_stall, MEM_fault, MEM_wb_en}); else pass_cnt++;
            tick();
            chk_cnt++; if ({DM_req, MEM_fault} !== 2'b00) $display("FAIL fault%0d_pulse got=%b want=00", k, {DM_req, MEM_fault}); else pass_cnt++;
        end
    endtask

    task automatic test_ack_idle();
        DM_ack = 1'b1; DM_rdata = 32'hFFFFFFFF;
        tick();
        DM_ack = 1'b0; DM_rdata = 32'd0;
        chk_cnt++; if ({MEM_wb_en, MEM_stall, DM_req, MEM_wb_val} !== {3'b000, 32'h00008001}) $display("FAIL ack_idle got=%h want=000008001", {MEM_wb_en, MEM_stall, DM_req, MEM_wb_val}); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int   sc;
        logic rok, wbs;
        issue(OP_ADDI, 3'b000, 32'h00001234, 32'd0, 5'd1);
        tick();
        issue(OP_LOAD, 3'b010, 32'h00000010, 32'd0, 5'd8);
        tick();
        chk_cnt++; if ({MEM_wb_val, DM_req, DM_addr} !== {32'h1234, 1'b1, 32'h10}) $display("FAIL b2b_start got=%h want=000012341_00000010", {MEM_wb_val, DM_req, DM_addr}); else pass_cnt++;
        issue(OP_ADDI, 3'b000, 32'h0BADF00D, 32'd0, 5'd9);
        run_access(2, 32'hDEADBEEF, sc, rok, wbs);
        EX_valid = 1'b0;
        chk_cnt++; if (sc !== 2 || rok !== 1'b1 || wbs !== 1'b0) $display("FAIL b2b_access got=%0d/%b/%b want=2/1/0", sc, rok, wbs); else pass_cnt++;
        chk_cnt++; if ({MEM_wb_en, MEM_rd, MEM_wb_val} !== {1'b1, 5'd8, 32'hDEADBEEF}) $display("FAIL b2b_wb got=%h want=1_08_deadbeef", {MEM_wb_en, MEM_rd, MEM_wb_val}); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_access();
        issue(OP_LOAD, 3'b010, 32'h00000400, 32'd0, 5'd4);
        tick();
        EX_valid = 1'b0;
        tick();
        chk_cnt++; if ({DM_req, MEM_stall} !== 2'b11) $display("FAIL rstacc_busy got=%b want=11", {DM_req, MEM_stall}); else pass_cnt++;
        rst_n = 1'b0;
        DM_ack = 1'b1; DM_rdata = 32'h12345678;
        tick();
        DM_ack = 1'b0; DM_rdata = 32'd0;
        chk_cnt++; if ({DM_req, MEM_stall, MEM_wb_en, MEM_wb_val} !== 35'd0) $display("FAIL rstacc_abandon got=%h want=0", {DM_req, MEM_stall, MEM_wb_en, MEM_wb_val}); else pass_cnt++;
        rst_n = 1'b1;
        issue(OP_ADDI, 3'b000, 32'h00000055, 32'd0, 5'd7);
        tick();
        EX_valid = 1'b0;
        chk_cnt++; if ({MEM_wb_en, MEM_rd, MEM_wb_val} !== {1'b1, 5'd7, 32'h55}) $display("FAIL rstacc_addi got=%h want=1_07_00000055", {MEM_wb_en, MEM_rd, MEM_wb_val}); else pass_cnt++;
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        int   sc;
        logic rok, wbs;
        issue(OP_LOAD, 3'b010, 32'h00000500, 32'd0, 5'd3);
        tick();
        EX_valid = 1'b0;
        run_access(0, 32'd0, sc, rok, wbs);
        chk_cnt++; if (sc !== 4 || rok !== 1'b1) $display("FAIL tmo_len got=%0d/%b want=4/1", sc, rok); else pass_cnt++;
        chk_cnt++; if ({MEM_fault, MEM_wb_en, DM_req, MEM_stall} !== 4'b1000) $display("FAIL tmo_fault got=%b want=1000", {MEM_fault, MEM_wb_en, DM_req, MEM_stall}); else pass_cnt++;
        DM_ack = 1'b1; DM_rdata = 32'hAAAAAAAA;
        tick();
        DM_ack = 1'b0; DM_rdata = 32'd0;
        chk_cnt++; if ({MEM_fault, MEM_wb_en, MEM_wb_val} !== {2'b00, 32'h55}) $display("FAIL tmo_stray got=%h want=0_00000055", {MEM_fault, MEM_wb_en, MEM_wb_val}); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_stores();
        test_faults();
        test_ack_idle();
        test_back_to_back();
        test_reset_access();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum number of ACCESS cycles before abort; it is used only when LSU_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk  in  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-004 SHALL have port EX_valid  in  1  instruction from the execute stage is valid this cycle.
REQ-005 SHALL have port EX_opcode  in  7  instruction opcode.
REQ-006 SHALL have port EX_fn_3  in  3  funct3 field (access width and signedness).
REQ-007 SHALL have port ALU_alu_val  in  32  ALU result: byte address for load/store, writeback data otherwise.
REQ-008 SHALL have port EX_rs2_val  in  32  store data.
REQ-009 SHALL have port EX_rd  in  5  destination register.
REQ-010 SHALL have port MEM_stall  out  1  upstream holds its outputs while this is high.
REQ-011 SHALL have port DM_req  out  1  data-memory request.
REQ-012 SHALL have port DM_we  out  1  request is a write.
REQ-013 SHALL have port DM_addr  out  32  word-aligned address, with bits [1:0] forced to 0.
REQ-014 SHALL have port DM_wdata  out  32  lane-replicated store data.
REQ-015 SHALL have port DM_be  out  4  byte enables.
REQ-016 SHALL have port DM_ack  in  1  memory completes the request this cycle.
REQ-017 SHALL have port DM_rdata  in  32  read word, valid when DM_ack is high.
REQ-018 SHALL have ports MEM_wb_val out 32, MEM_rd out 5, MEM_wb_en out 1 and MEM_fault out 1, carrying registered writeback data and destination, the write enable, and a one-cycle fault pulse.

Function
REQ-019 SHALL implement an FSM with two states: IDLE and ACCESS.
REQ-020 In IDLE, with EX_valid=1 and EX_opcode not 0000011 (LOAD) or 0100011 (STORE), SHALL register MEM_wb_val=ALU_alu_val and MEM_rd=EX_rd at the next edge; MEM_wb_en=1 when EX_rd≠0; latency is 1 cycle.
REQ-021 In IDLE, with EX_valid=1 and a LOAD or STORE that is legal and aligned, SHALL latch opcode, fn_3, address, rs2 and rd, then enter ACCESS.
REQ-022 Alignment: halfword accesses SHALL have addr[0]=0 and word accesses addr[1:0]=0; byte accesses are always aligned.
REQ-023 Legal loads are fn_3 000, 001, 010, 100 and 101; legal stores are 000, 001 and 010.
REQ-024 A misaligned or illegal LOAD/STORE SHALL NOT raise DM_req; the unit SHALL pulse MEM_fault=1 for one cycle, hold MEM_wb_en=0 and remain in IDLE.
REQ-025 In ACCESS, SHALL hold DM_req=1 and keep DM_we, DM_addr, DM_wdata and DM_be stable until the cycle in which DM_ack=1.
REQ-026 MEM_stall SHALL equal 1 exactly while the state is ACCESS, including the ack cycle, so EX inputs are ignored in ACCESS.
REQ-027 On the DM_ack edge, SHALL return to IDLE; for a load, SHALL register MEM_wb_val and MEM_wb_en=(rd≠0); for a store, MEM_wb_en=0.
REQ-028 Minimum load latency SHALL be 2 edges (accept edge plus ack edge).
REQ-029 Load extraction SHALL use lane addr[1:0] (byte) or addr[1] (halfword): LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
REQ-030 SB SHALL drive DM_be=0001<<addr[1:0] with the byte replicated ×4; SH SHALL drive DM_be=0011<<addr[1:0] with the halfword replicated ×2; SW SHALL drive DM_be=1111.
REQ-031 DM_ack while in IDLE SHALL be ignored.
REQ-032 MEM_wb_en and MEM_fault SHALL be single-cycle pulses per instruction; MEM_wb_val and MEM_rd hold their last value otherwise.

Reset
REQ-033 With rst_n=0 at a rising edge, SHALL set the state to IDLE and set DM_req, DM_we, MEM_wb_en and MEM_fault to 0, and DM_addr, DM_wdata, DM_be, MEM_wb_val and MEM_rd to 0.
REQ-034 Reset during ACCESS SHALL abandon the access with no writeback; DM_req SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-035 With LSU_TIMEOUT_EN defined, an ACCESS counter SHALL clear on entry; if TIMEOUT_CYCLES cycles elapse without DM_ack, the unit SHALL drop DM_req, pulse MEM_fault, write nothing and return to IDLE, and a later stray DM_ack SHALL be ignored.
REQ-036 Without LSU_TIMEOUT_EN, SHALL contain no counter and wait in ACCESS indefinitely.

Verification
REQ-037 ADDI result: ALU_alu_val=0x0000002A, rd=5 -> next cycle MEM_wb_val=0x2A, MEM_rd=5, MEM_wb_en=1, MEM_stall=0.
REQ-038 LB at addr 0x103, ack after 3 cycles with DM_rdata=0x80000000 -> DM_addr=0x100, MEM_stall high for 3 cycles, MEM_wb_val=0xFFFFFF80; LBU variant -> 0x00000080.
REQ-039 SH at 0x202 with rs2=0x1234ABCD -> DM_be=1100, DM_wdata=0xABCDABCD, DM_we=1, MEM_wb_en=0 after ack.
REQ-040 LW at 0x101 -> no DM_req, MEM_fault one-cycle pulse, MEM_wb_en=0.
REQ-041 rst_n=0 during ACCESS for LW -> DM_req=0 next cycle, no writeback, new ADDI accepted after reset released.
REQ-042 With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, with DM_ack never asserted -> DM_req high 4 cycles, then MEM_fault pulse, then IDLE.
